// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants, state/select enums and small decode helpers.
package riscv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;
    typedef enum logic {RUN, STALL} of_state_e;
    typedef enum logic [2:0] {FWD_ZERO, FWD_EX, FWD_MEM, FWD_WB, FWD_RF} fwd_sel_e;

    function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
        imm_type_e t;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: t = IMM_I;
            OP_STORE:                 t = IMM_S;
            OP_BRANCH:                t = IMM_B;
            OP_LUI, OP_AUIPC:         t = IMM_U;
            OP_JAL:                   t = IMM_J;
            default:                  t = IMM_NONE;
        endcase
        return t;
    endfunction

    // U and J formats carry no rs1 field; their bits there are immediate.
    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_REG || opcode == OP_STORE || opcode == OP_BRANCH);
    endfunction

    // Youngest producer wins; x0 is hard-wired and never forwarded.
    function automatic fwd_sel_e fwd_select(input logic [4:0] src,
                                            input logic ex_hit,
                                            input logic mem_hit,
                                            input logic wb_hit);
        fwd_sel_e s;
        if (src == 5'd0)  s = FWD_ZERO;
        else if (ex_hit)  s = FWD_EX;
        else if (mem_hit) s = FWD_MEM;
        else if (wb_hit)  s = FWD_WB;
        else              s = FWD_RF;
        return s;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: sign-extends the I/S/B/U/J immediate
// selected by opcode; unrecognised opcodes yield zero.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    imm_type_e imm_type;
    logic      sign;

    assign imm_type = imm_type_of(instr[6:0]);
    assign sign     = instr[31];

    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I: imm = {{(XLEN-12){sign}}, instr[31:20]};
            IMM_S: imm = {{(XLEN-12){sign}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{(XLEN-13){sign}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
            IMM_U: imm = {{(XLEN-32){sign}}, instr[31:12], 12'b0};
            IMM_J: imm = {{(XLEN-21){sign}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: forwards from EX/MEM/WB, stalls on load-use and
// registers resolved operands into the ID/EX register under valid/ready.
module operand_fetch
    import riscv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [31:0]            in_instr,
    output logic [4:0]             rs1,
    output logic [4:0]             rs2,
    input  logic [XLEN-1:0]        read_data1,
    input  logic [XLEN-1:0]        read_data2,
    input  logic                   ex_fwd_valid,
    input  logic [4:0]             ex_fwd_rd,
    input  logic [XLEN-1:0]        ex_fwd_data,
    input  logic                   ex_is_load,
    input  logic                   mem_fwd_valid,
    input  logic [4:0]             mem_fwd_rd,
    input  logic [XLEN-1:0]        mem_fwd_data,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_rd,
    input  logic [XLEN-1:0]        wb_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_op1,
    output logic [XLEN-1:0]        out_op2,
    output logic [XLEN-1:0]        out_imm,
    output logic [4:0]             out_rd,
    output logic [6:0]             out_opcode,
    output logic [9:0]             out_funct,
    output logic                   pipe_clk_en,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    of_state_e       state, state_nxt;
    logic            state_can_accept;
    logic [6:0]      opcode;
    logic            hazard;
    logic            capture;
    fwd_sel_e        sel1, sel2;
    logic [XLEN-1:0] op1, op2, imm;

    assign opcode = in_instr[6:0];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr),
        .imm   (imm)
    );

    // A load in EX has no data yet, so it must not be forwarded from EX.
    assign sel1 = fwd_select(rs1,
                             ex_fwd_valid && !ex_is_load && (ex_fwd_rd == rs1),
                             mem_fwd_valid && (mem_fwd_rd == rs1),
                             wb_valid && (wb_rd == rs1));
    assign sel2 = fwd_select(rs2,
                             ex_fwd_valid && !ex_is_load && (ex_fwd_rd == rs2),
                             mem_fwd_valid && (mem_fwd_rd == rs2),
                             wb_valid && (wb_rd == rs2));

    always_comb begin
        op1 = read_data1;
        case (sel1)
            FWD_ZERO: op1 = '0;
            FWD_EX:   op1 = ex_fwd_data;
            FWD_MEM:  op1 = mem_fwd_data;
            FWD_WB:   op1 = wb_data;
            default:  op1 = read_data1;
        endcase
    end

    always_comb begin
        op2 = read_data2;
        case (sel2)
            FWD_ZERO: op2 = '0;
            FWD_EX:   op2 = ex_fwd_data;
            FWD_MEM:  op2 = mem_fwd_data;
            FWD_WB:   op2 = wb_data;
            default:  op2 = read_data2;
        endcase
    end

    assign hazard = ex_is_load && (ex_fwd_rd != 5'd0) &&
                    ((uses_rs1(opcode) && (ex_fwd_rd == rs1)) ||
                     (uses_rs2(opcode) && (ex_fwd_rd == rs2)));

    // STALL releases in the same cycle the hazard clears, so a load followed
    // by a dependent instruction costs exactly one bubble.
    always_comb begin
        state_nxt        = state;
        state_can_accept = 1'b1;
        case (state)
            RUN: begin
                if (in_valid && hazard)
                    state_nxt = STALL;
            end
            STALL: begin
                state_can_accept = !hazard;
                if (!hazard)
                    state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
        if (flush)
            state_nxt = RUN;
    end

    assign in_ready    = reset_n && state_can_accept && !hazard && (!out_valid || out_ready);
    assign capture     = in_valid && in_ready && !flush;
    assign pipe_clk_en = capture || (out_valid && out_ready) || flush || !reset_n;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= RUN;
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_op1    <= '0;
            out_op2    <= '0;
            out_imm    <= '0;
            out_rd     <= '0;
            out_opcode <= '0;
            out_funct  <= '0;
            stall_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (in_valid && hazard && (stall_cnt != {STALL_CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
            if (flush) begin
                out_valid <= 1'b0;
            end else if (capture) begin
                out_valid  <= 1'b1;
                out_pc     <= in_pc;
                out_op1    <= op1;
                out_op2    <= op2;
                out_imm    <= imm;
                out_rd     <= in_instr[11:7];
                out_opcode <= opcode;
                out_funct  <= {in_instr[31:25], in_instr[14:12]};
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch.
module tb_operand_fetch;

    localparam int XLEN = 32;
    localparam int SCW  = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_instr;
    logic [4:0]      rs1, rs2;
    logic [XLEN-1:0] read_data1, read_data2;
    logic            ex_fwd_valid;
    logic [4:0]      ex_fwd_rd;
    logic [XLEN-1:0] ex_fwd_data;
    logic            ex_is_load;
    logic            mem_fwd_valid;
    logic [4:0]      mem_fwd_rd;
    logic [XLEN-1:0] mem_fwd_data;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc, out_op1, out_op2, out_imm;
    logic [4:0]      out_rd;
    logic [6:0]      out_opcode;
    logic [9:0]      out_funct;
    logic            pipe_clk_en;
    logic [SCW-1:0]  stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] I_ADDI_X5  = 32'hFFC08293; // addi x5,x1,-4
    localparam logic [31:0] I_ADDI_X3  = 32'h00118493; // addi x9,x3,1
    localparam logic [31:0] I_ADD_LU   = 32'h00238433; // add x8,x7,x2
    localparam logic [31:0] I_ADDI_X0  = 32'h00500493; // addi x9,x0,5

    operand_fetch #(.XLEN(XLEN), .STALL_CNT_W(SCW)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .rs1(rs1), .rs2(rs2), .read_data1(read_data1), .read_data2(read_data2),
        .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
        .ex_is_load(ex_is_load),
        .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
        .out_rd(out_rd), .out_opcode(out_opcode), .out_funct(out_funct),
        .pipe_clk_en(pipe_clk_en), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        ex_fwd_valid  = 1'b0; ex_fwd_rd  = '0; ex_fwd_data  = '0; ex_is_load = 1'b0;
        mem_fwd_valid = 1'b0; mem_fwd_rd = '0; mem_fwd_data = '0;
        wb_valid      = 1'b0; wb_rd      = '0; wb_data      = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b1; in_pc = 32'h100; in_instr = I_ADDI_X5;
        read_data1 = 32'h10; read_data2 = '0; flush = 1'b0; out_ready = 1'b1;
        clear_fwd();
        repeat (3) step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
        n_checks++;
        if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
        n_checks++;
        if (out_pc !== 32'd0) begin n_fail++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
        in_valid = 1'b0;
        reset_n  = 1'b1;
        step();
    endtask

    task automatic test_plain_issue();
        in_valid = 1'b1; in_pc = 32'h100; in_instr = I_ADDI_X5; read_data1 = 32'h10;
        #1;
        n_checks++;
        if (rs1 !== 5'd1) begin n_fail++; $display("FAIL plain_rs1 got %0d want 1", rs1); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL plain_in_ready got %0b want 1", in_ready); end
        n_checks++;
        if (pipe_clk_en !== 1'b1) begin n_fail++; $display("FAIL plain_clk_en got %0b want 1", pipe_clk_en); end
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL plain_out_valid got %0b want 1", out_valid); end
        n_checks++;
        if (out_op1 !== 32'h10) begin n_fail++; $display("FAIL plain_op1 got %h want 00000010", out_op1); end
        n_checks++;
        if (out_imm !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL plain_imm got %h want fffffffc", out_imm); end
        n_checks++;
        if (out_rd !== 5'd5) begin n_fail++; $display("FAIL plain_rd got %0d want 5", out_rd); end
        n_checks++;
        if (out_opcode !== 7'h13) begin n_fail++; $display("FAIL plain_opcode got %h want 13", out_opcode); end
        n_checks++;
        if (out_pc !== 32'h100) begin n_fail++; $display("FAIL plain_pc got %h want 00000100", out_pc); end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL plain_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_forward_priority();
        logic [XLEN-1:0] exp_op1 [4];
        exp_op1[0] = 32'hA; exp_op1[1] = 32'hB; exp_op1[2] = 32'hC; exp_op1[3] = 32'h99;
        for (int k = 0; k < 4; k++) begin
            clear_fwd();
            in_instr = I_ADDI_X3; in_pc = 32'h104; read_data1 = 32'h99;
            ex_fwd_rd = 5'd3; ex_fwd_data = 32'hA;
            mem_fwd_rd = 5'd3; mem_fwd_data = 32'hB;
            wb_rd = 5'd3; wb_data = 32'hC;
            ex_fwd_valid  = (k == 0);
            mem_fwd_valid = (k <= 1);
            wb_valid      = (k <= 2);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            n_checks++;
            if (out_op1 !== exp_op1[k]) begin
                n_fail++; $display("FAIL fwd_prio_%0d op1 got %h want %h", k, out_op1, exp_op1[k]);
            end
        end
        clear_fwd();
        step();
    endtask

    task automatic test_rs2_unused();
        // rs2 field of an I-type is immediate, so a matching load is no hazard.
        in_instr = I_ADDI_X3; in_valid = 1'b1;
        ex_is_load = 1'b1; ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rs2_unused_ready got %0b want 1", in_ready); end
        in_valid = 1'b0;
        clear_fwd();
        step();
        step();
    endtask

    task automatic test_load_use();
        in_instr = I_ADD_LU; in_pc = 32'h108; in_valid = 1'b1;
        read_data1 = 32'h77; read_data2 = 32'h22;
        ex_is_load = 1'b1; ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd7; ex_fwd_data = 32'hBAD;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL lu_in_ready got %0b want 0", in_ready); end
        n_checks++;
        if (pipe_clk_en !== 1'b0) begin n_fail++; $display("FAIL lu_clk_en got %0b want 0", pipe_clk_en); end
        step();
        n_checks++;
        if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt got %0d want 1", stall_cnt); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lu_no_capture got %0b want 0", out_valid); end
        clear_fwd();
        mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd7; mem_fwd_data = 32'h55;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lu_out_valid got %0b want 1", out_valid); end
        n_checks++;
        if (out_op1 !== 32'h55) begin n_fail++; $display("FAIL lu_op1 got %h want 00000055", out_op1); end
        n_checks++;
        if (out_op2 !== 32'h22) begin n_fail++; $display("FAIL lu_op2 got %h want 00000022", out_op2); end
        n_checks++;
        if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_stall_hold got %0d want 1", stall_cnt); end
        clear_fwd();
        step();
    endtask

    task automatic test_backpressure_flush();
        out_ready = 1'b0;
        in_instr = I_ADDI_X5; in_pc = 32'h200; read_data1 = 32'h10; in_valid = 1'b1;
        step();
        in_instr = I_ADDI_X3; in_pc = 32'h204; read_data1 = 32'h33;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (pipe_clk_en !== 1'b0) begin n_fail++; $display("FAIL bp_clk_en_%0d got %0b want 0", c, pipe_clk_en); end
            n_checks++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_%0d got %0b want 0", c, in_ready); end
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_op1 !== 32'h10) begin
                n_fail++;
                $display("FAIL bp_hold_%0d got v=%0b pc=%h op1=%h want v=1 pc=00000200 op1=00000010",
                         c, out_valid, out_pc, out_op1);
            end
        end
        flush = 1'b1;
        #1;
        n_checks++;
        if (pipe_clk_en !== 1'b1) begin n_fail++; $display("FAIL flush_clk_en got %0b want 1", pipe_clk_en); end
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %0b want 0", out_valid); end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped got %0b want 0", out_valid); end
    endtask

    task automatic test_x0_source();
        clear_fwd();
        in_instr = I_ADDI_X0; in_pc = 32'h300; read_data1 = 32'h1234; in_valid = 1'b1;
        ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd0; ex_fwd_data = 32'hDEAD;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_op1 !== 32'd0) begin n_fail++; $display("FAIL x0_op1 got %h want 00000000", out_op1); end
        n_checks++;
        if (out_imm !== 32'd5) begin n_fail++; $display("FAIL x0_imm got %h want 00000005", out_imm); end
        clear_fwd();
        step();
    endtask

    initial begin
        test_reset();
        test_plain_issue();
        test_forward_priority();
        test_rs2_unused();
        test_load_use();
        test_backpressure_flush();
        test_x0_source();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode/operand-fetch stage sitting directly upstream of `reg_file`. It accepts a fetched instruction, drives the register-file read addresses, and resolves read-after-write hazards. Hazards are handled by forwarding from EX, MEM and WB, or by stalling on load-use. The resolved operands, immediate and control fields are registered into the ID/EX pipeline register under a valid/ready handshake. It also produces the clock-enable for that register's gated clock.

## Interface
Parameters:
- `XLEN`, 32, data and address width
- `STALL_CNT_W`, 16, width of stall performance counter

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  clock
- `reset_n`  in  1  synchronous active-low reset
- `in_valid`  in  1  instruction valid from fetch
- `in_ready`  out  1  stage can accept instruction
- `in_pc`  in  XLEN  instruction PC
- `in_instr`  in  32  instruction word
- `rs1`  out  5  regfile read address 1, `in_instr[19:15]`, combinational
- `rs2`  out  5  regfile read address 2, `in_instr[24:20]`, combinational
- `read_data1`  in  XLEN  regfile data for rs1, combinational, same cycle
- `read_data2`  in  XLEN  regfile data for rs2, combinational, same cycle
- `ex_fwd_valid`  in  1  EX produces an ALU result this cycle
- `ex_fwd_rd`  in  5  EX destination register
- `ex_fwd_data`  in  XLEN  EX result
- `ex_is_load`  in  1  EX holds a load; data not yet available
- `mem_fwd_valid`  in  1  MEM result valid
- `mem_fwd_rd`  in  5  MEM destination register
- `mem_fwd_data`  in  XLEN  MEM result, including load data
- `wb_valid`  in  1  WB writes regfile this cycle; same signal as `reg_write`
- `wb_rd`  in  5  WB destination register
- `wb_data`  in  XLEN  WB data
- `flush`  in  1  kill the instruction being accepted and the held output
- `out_valid`  out  1  ID/EX register valid
- `out_ready`  in  1  EX accepts
- `out_pc`  out  XLEN  registered PC
- `out_op1`  out  XLEN  resolved rs1 value
- `out_op2`  out  XLEN  resolved rs2 value
- `out_imm`  out  XLEN  sign-extended immediate
- `out_rd`  out  5  destination register
- `out_opcode`  out  7  `instr[6:0]`
- `out_funct`  out  10  `{funct7, funct3}`
- `pipe_clk_en`  out  1  clock-gate enable for ID/EX register
- `stall_cnt`  out  STALL_CNT_W  load-use stall cycles, saturating

## Operation
- **Operand resolution**, for each source `s`, in priority order:
  - `s==0` → 0.
  - EX match with `ex_fwd_valid && !ex_is_load` → `ex_fwd_data`.
  - MEM match → `mem_fwd_data`.
  - WB match → `wb_data`. This bypass is needed because the regfile write lands only at the next edge.
  - Otherwise → `read_data`.
- **Load-use hazard**: `ex_is_load && ex_fwd_rd!=0 && ex_fwd_rd` equals a used source. `rs2` counts as used only for R, S and B formats.
- **Immediate**: I, S, B, U, J format selected by opcode; unknown opcodes → 0.
- **FSM states**:
  - `RUN`: go to `STALL` on a load-use hazard with `in_valid`.
  - `STALL`: `in_ready=0`, no capture. Return to `RUN` when the hazard clears, normally after 1 cycle once the load moves to MEM.
  - `flush` forces `RUN`.
- **Handshake**:
  - `in_ready = state_can_accept && !hazard && (!out_valid || out_ready)`.
  - Capture on `in_valid && in_ready && !flush`.
  - `out_valid` is cleared when `out_ready` is high and nothing is captured.
- **Clock enable**: `pipe_clk_en` = capture, or `out_valid` clearing, or `flush`, or reset. It is held low while stalled with the output blocked.
- **Stall counter**: `stall_cnt` increments each cycle `in_valid && hazard`. It saturates at all-ones.

## Timing
- **Reset**: on a `reset_n` low edge, all `out_*`=0, `out_valid`=0, `stall_cnt`=0, state `RUN`. `in_ready` is 0 while `reset_n` is low.
- **Latency**: 1 cycle from accepted input to `out_valid`. `rs1`/`rs2` are driven the same cycle.
- **Back-pressure**: outputs hold stable while `out_valid && !out_ready`.
- **Flush**:
  - Next cycle `out_valid`=0; a simultaneous input is dropped.
  - Reset dominates flush.
  - Flush in `STALL` returns to `RUN`.
- **Simultaneous matches**: EX, MEM and WB all matching the same rd → EX wins (youngest).
- **Forwarding to x0** is never applied.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants (`OP_LUI`, `OP_AUIPC`, `OP_JAL`, `OP_JALR`, `OP_BRANCH`, `OP_LOAD`, `OP_STORE`, `OP_IMM`, `OP_REG`)
  - `imm_type_e` enum
  - `of_state_e {RUN, STALL}`
  - `fwd_sel_e {FWD_ZERO, FWD_EX, FWD_MEM, FWD_WB, FWD_RF}`
- One sub-module `imm_gen`: combinational, takes the instruction word and produces the immediate.

## Test plan
- **Reset**: hold `reset_n`=0 for 3 cycles with `in_valid`=1 → `out_valid`=0, `in_ready`=0, `stall_cnt`=0.
- **Plain issue**:
  - Stimulus: `addi x5,x1,-4` (0xFFC08293), `read_data1`=0x10.
  - Required response, next cycle: `out_op1`=0x10, `out_imm`=0xFFFFFFFC, `out_rd`=5.
- **Forward priority**:
  - Stimulus: rs1=x3 with EX(x3=0xA), MEM(x3=0xB), WB(x3=0xC) all active.
  - Required response: `out_op1`=0xA. With EX dropped → 0xB; with only WB → 0xC.
- **Load-use**:
  - Stimulus: `ex_is_load`=1, `ex_fwd_rd`=7, incoming `add x8,x7,x2`.
  - Required response: one cycle with `in_ready`=0 and `stall_cnt`=1. Next cycle MEM forwards 0x55 → `out_op1`=0x55.
- **Back-pressure then flush**: `out_ready`=0 for 4 cycles → outputs stable and `pipe_clk_en`=0. Assert `flush` → `out_valid`=0 next cycle.
- **x0 source**: rs1=x0 with EX forwarding rd=0 data 0xDEAD → `out_op1`=0.
